// File: rtl/data_distributor14.sv
// data_distributor14: registered 1-to-4 distributor with valid/ready handshakes.
// Ports: iClk, iRst_n, iData/iValid/oReady (input stream), iS1/iS0/iRr (routing),
//        oD0..oD3/oValid/iReady (four output channels), oPtr (next round-robin
//        destination), oTotal (words accepted since reset, wrapping).
module data_distributor14 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [WIDTH-1:0] iData,
    input  logic             iValid,
    output logic             oReady,
    input  logic             iS1,
    input  logic             iS0,
    input  logic             iRr,
    output logic [WIDTH-1:0] oD0,
    output logic [WIDTH-1:0] oD1,
    output logic [WIDTH-1:0] oD2,
    output logic [WIDTH-1:0] oD3,
    output logic [3:0]       oValid,
    input  logic [3:0]       iReady,
    output logic [1:0]       oPtr,
    output logic [CNT_W-1:0] oTotal
);

    logic [WIDTH-1:0] chData [4];
    logic [1:0]       dest;
    logic             accept;
    logic [3:0]       load;

    assign dest   = iRr ? oPtr : {iS1, iS0};
    // A full channel can still take a word when its sink drains it this cycle.
    assign oReady = ~oValid[dest] | iReady[dest];
    assign accept = iValid & oReady;

    always_comb begin
        load = 4'b0000;
        if (accept) begin
            load[dest] = 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int k = 0; k < 4; k++) begin
                chData[k] <= '0;
            end
            oValid <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    chData[k] <= iData;
                    oValid[k] <= 1'b1;
                end else if (iReady[k]) begin
                    oValid[k] <= 1'b0;
                end
            end
        end
    end

    // The pointer only moves on round-robin accepts, so a stalled channel
    // holds the stream rather than being skipped.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oPtr   <= 2'd0;
            oTotal <= '0;
        end else if (accept) begin
            oTotal <= oTotal + 1'b1;
            if (iRr) begin
                oPtr <= oPtr + 2'd1;
            end
        end
    end

    assign oD0 = chData[0];
    assign oD1 = chData[1];
    assign oD2 = chData[2];
    assign oD3 = chData[3];

endmodule
